instr_mem_loader: RTL and testbench
===================================

Name: instr_mem_loader

Overview:
- Writer-side counterpart to the read-only instruction memory port used by the fetch stage.
- Accepts a byte stream carrying a program image over a valid/ready handshake and assembles 16-bit instruction words.
- Issues single-cycle write pulses into instruction memory storage.
- Holds the CPU (`cpu_hold`, which gates the PC/register-file reset path) while a load is in progress or has failed.

Parameters:
- `DEPTH`, 256, maximum number of instruction words the image may contain.
- `BASE_ADDR`, 16'h0000, instruction-memory address written by word 0.
- `TIMEOUT`, 1024, idle cycles without a byte while receiving before aborting to ERR.

Ports:
- `clk`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `load_start`  in  1  one-cycle request to begin a load; honoured in IDLE, DONE, ERR only.
- `byte_in`  in  8  stream data byte.
- `byte_valid`  in  1  `byte_in` is valid.
- `byte_ready`  out  1  loader can accept a byte this cycle.
- `wr_en`  out  1  instruction-memory write strobe, one cycle per word.
- `wr_addr`  out  16  write address.
- `wr_data`  out  16  instruction word.
- `cpu_hold`  out  1  CPU held in reset/stall.
- `busy`  out  1  load in progress (CNT_HI..CHK).
- `done`  out  1  level; image loaded and checksum good.
- `err`  out  1  level; load aborted (bad checksum, oversize, timeout).

Behaviour:
- Handshake: a byte transfers when `byte_valid & byte_ready`. `byte_ready` = 1 exactly in CNT_HI, CNT_LO, DATA_HI, DATA_LO, CHK.
- Frame format, in byte order:
  - count high byte, then count low byte (N words, big-endian);
  - N words, each high byte then low byte;
  - one checksum byte = XOR of every preceding byte of the frame.
- States and transitions:
  - IDLE -> CNT_HI on `load_start`.
  - CNT_HI -> CNT_LO on transfer.
  - CNT_LO on transfer: go to ERR if N > `DEPTH`; go to CHK if N == 0; otherwise go to DATA_HI.
  - DATA_HI -> DATA_LO on transfer.
  - DATA_LO on transfer: go to CHK if this was the last word, otherwise go to DATA_HI.
  - CHK on transfer: go to DONE if byte == running XOR, otherwise go to ERR.
  - DONE or ERR -> CNT_HI on `load_start`; word index and XOR are cleared.
- `load_start` during CNT_HI..CHK is ignored.
- Running XOR is cleared on entry to CNT_HI. It accumulates every transferred byte except the checksum byte itself.
- Write timing:
  - On a DATA_LO transfer, `wr_en` = 1 on the following cycle only.
  - `wr_data` = {high byte, low byte}; `wr_addr` = `BASE_ADDR` + word index (16-bit wrap-around).
  - Index increments after each write.
  - `wr_addr`/`wr_data` hold their last values when `wr_en` = 0.
- Timeout: a counter resets on every transfer and on state entry, and increments each cycle in CNT_HI..CHK with no transfer. Reaching `TIMEOUT` -> ERR.
- Output decode:
  - `cpu_hold` = 1 in CNT_HI..CHK and ERR; 0 in IDLE and DONE.
  - `busy` = 1 in CNT_HI..CHK.
  - `done` = 1 in DONE only; `err` = 1 in ERR only.
- All outputs registered or decoded from registered state; no combinational path from `byte_valid` to `byte_ready`.
- Reset (any state, including mid-load or during a pending write):
  - state = IDLE; `byte_ready`, `wr_en`, `cpu_hold`, `busy`, `done`, `err` = 0; `wr_addr` = `BASE_ADDR`; `wr_data` = 0; index, XOR and timeout counter = 0.
  - A write pending at reset is dropped.
- Simultaneous transfer and timeout in the same cycle: the transfer wins; the counter clears.

Decomposition:
- Shared package `mips16_pkg`:
  - loader state encoding (IDLE=0, CNT_HI, CNT_LO, DATA_HI, DATA_LO, CHK, DONE, ERR; 3 bits);
  - `INSTR_W`=16;
  - `ADDR_W`=16.
- One sub-module, `loader_timeout_ctr`: counter with clear/enable inputs and a terminal flag; width derived from `TIMEOUT`.
- FSM, assembler and checksum remain in the top module.

Test Plan:
- Normal load: `load_start`, then bytes 00 02 12 34 AB CD 42 -> `wr_en` pulses write 0x0000=0x1234 and 0x0001=0xABCD; `done`=1, `cpu_hold`=0, `err`=0.
- Bad checksum: same frame with last byte 43 -> both writes occur, then `err`=1, `cpu_hold` stays 1; next `load_start` with a good frame -> `done`=1.
- Empty image: bytes 00 00 00 -> no `wr_en`, `done`=1.
- Oversize: count bytes 01 01 (N=257 > `DEPTH`) -> `err`=1 the cycle after the second byte; `byte_ready`=0 and no writes.
- Backpressure/timeout: gaps of 5 cycles between bytes of a normal frame -> identical result to the normal load. Stall for `TIMEOUT` cycles after DATA_HI -> `err`=1.
- Reset mid-load: assert `reset` the same cycle as a DATA_LO transfer -> no `wr_en` next cycle; all outputs at reset values; IDLE.

Source files
------------

// File: rtl/mips16_pkg.sv
// ----------------------------------------------------------------------------
// mips16_pkg
// Shared definitions for the MIPS16 instruction-memory loader.
//   loader_state_t   : 3-bit loader FSM state encoding
//   INSTR_W / ADDR_W : instruction word and address widths
//   is_busy_state()  : true for the states that make up an active load
// ----------------------------------------------------------------------------
package mips16_pkg;

    localparam int INSTR_W = 16;
    localparam int ADDR_W  = 16;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CNT_HI  = 3'd1,
        ST_CNT_LO  = 3'd2,
        ST_DATA_HI = 3'd3,
        ST_DATA_LO = 3'd4,
        ST_CHK     = 3'd5,
        ST_DONE    = 3'd6,
        ST_ERR     = 3'd7
    } loader_state_t;

    // The active-load states are exactly the ones that accept stream bytes.
    function automatic logic is_busy_state(input loader_state_t s);
        return (s == ST_CNT_HI) || (s == ST_CNT_LO) || (s == ST_DATA_HI) ||
               (s == ST_DATA_LO) || (s == ST_CHK);
    endfunction

endpackage

// File: rtl/loader_timeout_ctr.sv
// ----------------------------------------------------------------------------
// loader_timeout_ctr
// Idle-cycle counter that flags when a load has waited too long for a byte.
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   clear      : zero the count (a byte moved, or no load is active)
//   enable     : count this cycle (load active and no byte moved)
//   expired    : this enabled cycle is the TIMEOUT-th idle cycle in a row
// ----------------------------------------------------------------------------
module loader_timeout_ctr #(
    parameter int TIMEOUT = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int W = $clog2(TIMEOUT + 1);
    localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

    logic [W-1:0] count;

    // Clear has priority so a transfer in the same cycle always wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + W'(1);
        end
    end

    // Flag on the cycle that would bring the count up to TIMEOUT, so the FSM
    // leaves on that same edge.
    assign expired = enable && !clear && (count == LAST);

endmodule

// File: rtl/instr_mem_loader.sv
// ----------------------------------------------------------------------------
// instr_mem_loader
// Receives a program image as a byte stream (valid/ready), assembles 16-bit
// instruction words and writes them into instruction memory, holding the CPU
// while a load is running or has failed.
// Frame: count_hi, count_lo, N x {word_hi, word_lo}, xor_checksum.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   load_start            : begin a load (honoured in IDLE/DONE/ERR)
//   byte_in, byte_valid   : stream data and its qualifier
//   byte_ready            : loader accepts a byte this cycle
//   wr_en, wr_addr, wr_data : one-cycle instruction-memory write
//   cpu_hold              : CPU held (loading or failed)
//   busy, done, err       : load in progress / succeeded / aborted
// ----------------------------------------------------------------------------
module instr_mem_loader
    import mips16_pkg::*;
#(
    parameter int          DEPTH     = 256,
    parameter logic [15:0] BASE_ADDR = 16'h0000,
    parameter int          TIMEOUT   = 1024
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load_start,
    input  logic [7:0]         byte_in,
    input  logic               byte_valid,
    output logic               byte_ready,
    output logic               wr_en,
    output logic [ADDR_W-1:0]  wr_addr,
    output logic [INSTR_W-1:0] wr_data,
    output logic               cpu_hold,
    output logic               busy,
    output logic               done,
    output logic               err
);

    localparam logic [16:0] DEPTH_L = 17'(DEPTH);

    loader_state_t state;
    loader_state_t state_next;

    logic [7:0]  count_hi;
    logic [15:0] word_count;
    logic [7:0]  word_hi;
    logic [15:0] word_index;
    logic [7:0]  run_xor;
    logic [15:0] count_rx;

    logic transfer;
    logic expired;
    logic start_load;

    // byte_ready is a registered state decode, so this has no path from
    // byte_valid back into byte_ready.
    assign transfer   = byte_valid && byte_ready;
    assign start_load = load_start &&
                        ((state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERR));
    assign count_rx   = {count_hi, byte_in};

    loader_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .clear   (transfer || !busy),
        .enable  (busy && !transfer),
        .expired (expired)
    );

    // Next-state logic. A transfer is checked before the timeout so that a
    // byte arriving on the expiry cycle keeps the load alive.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start_load) state_next = ST_CNT_HI;
            end
            ST_CNT_HI: begin
                if (transfer)     state_next = ST_CNT_LO;
                else if (expired) state_next = ST_ERR;
            end
            ST_CNT_LO: begin
                if (transfer) begin
                    if ({1'b0, count_rx} > DEPTH_L) state_next = ST_ERR;
                    else if (count_rx == 16'd0)     state_next = ST_CHK;
                    else                            state_next = ST_DATA_HI;
                end else if (expired) begin
                    state_next = ST_ERR;
                end
            end
            ST_DATA_HI: begin
                if (transfer)     state_next = ST_DATA_LO;
                else if (expired) state_next = ST_ERR;
            end
            ST_DATA_LO: begin
                if (transfer) begin
                    if (word_index + 16'd1 == word_count) state_next = ST_CHK;
                    else                                  state_next = ST_DATA_HI;
                end else if (expired) begin
                    state_next = ST_ERR;
                end
            end
            ST_CHK: begin
                if (transfer)     state_next = (byte_in == run_xor) ? ST_DONE : ST_ERR;
                else if (expired) state_next = ST_ERR;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // State register with all status outputs registered from the next state,
    // so every output lines up with the state it describes.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            byte_ready <= 1'b0;
            busy       <= 1'b0;
            cpu_hold   <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            state      <= state_next;
            byte_ready <= is_busy_state(state_next);
            busy       <= is_busy_state(state_next);
            cpu_hold   <= is_busy_state(state_next) || (state_next == ST_ERR);
            done       <= (state_next == ST_DONE);
            err        <= (state_next == ST_ERR);
        end
    end

    // Frame datapath: captures the count, pairs bytes into words, keeps the
    // running XOR and launches a single-cycle write after each low byte.
    // The write address uses the index before it increments, so word k lands
    // at BASE_ADDR + k with natural 16-bit wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_hi   <= '0;
            word_count <= '0;
            word_hi    <= '0;
            word_index <= '0;
            run_xor    <= '0;
            wr_en      <= 1'b0;
            wr_addr    <= BASE_ADDR;
            wr_data    <= '0;
        end else begin
            wr_en <= 1'b0;
            if (start_load) begin
                word_index <= '0;
                run_xor    <= '0;
            end else if (transfer) begin
                case (state)
                    ST_CNT_HI: begin
                        count_hi <= byte_in;
                        run_xor  <= run_xor ^ byte_in;
                    end
                    ST_CNT_LO: begin
                        word_count <= count_rx;
                        run_xor    <= run_xor ^ byte_in;
                    end
                    ST_DATA_HI: begin
                        word_hi <= byte_in;
                        run_xor <= run_xor ^ byte_in;
                    end
                    ST_DATA_LO: begin
                        wr_en      <= 1'b1;
                        wr_data    <= {word_hi, byte_in};
                        wr_addr    <= BASE_ADDR + word_index;
                        word_index <= word_index + 16'd1;
                        run_xor    <= run_xor ^ byte_in;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_instr_mem_loader.sv
// ----------------------------------------------------------------------------
// tb_instr_mem_loader
// Directed self-checking bench for instr_mem_loader: normal, bad checksum,
// empty, oversize, backpressure, timeout and reset-during-write scenarios.
// ----------------------------------------------------------------------------
module tb_instr_mem_loader;

    localparam int TB_TIMEOUT = 40;

    logic        clk;
    logic        reset;
    logic        load_start;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic        wr_en;
    logic [15:0] wr_addr;
    logic [15:0] wr_data;
    logic        cpu_hold;
    logic        busy;
    logic        done;
    logic        err;

    int checkCount;
    int failCount;

    logic [15:0] seenAddr[$];
    logic [15:0] seenData[$];

    instr_mem_loader #(
        .DEPTH     (256),
        .BASE_ADDR (16'h0000),
        .TIMEOUT   (TB_TIMEOUT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .load_start (load_start),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .cpu_hold   (cpu_hold),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    // 100 MHz clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every write strobe, sampled mid-cycle away from the edge.
    always @(negedge clk) begin
        if (wr_en) begin
            seenAddr.push_back(wr_addr);
            seenData.push_back(wr_data);
        end
    end

    // Single comparison point for the whole bench.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present one byte after 'gap' idle cycles and hold it until accepted.
    task automatic applyStimulus(input logic [7:0] b, input int gap);
        int waited;
        repeat (gap) @(posedge clk);
        #1;
        byte_in    = b;
        byte_valid = 1'b1;
        waited     = 0;
        while (!byte_ready && waited < 20) begin
            @(posedge clk);
            #1;
            waited++;
        end
        if (!byte_ready) checkOutput("ready_wait", 32'(byte_ready), 32'd1);
        @(posedge clk);
        #1;
        byte_valid = 1'b0;
    endtask

    task automatic pulseStart();
        load_start = 1'b1;
        @(posedge clk);
        #1;
        load_start = 1'b0;
    endtask

    task automatic sendFrame(input logic [7:0] frame[$], input int gap);
        foreach (frame[i]) applyStimulus(frame[i], gap);
    endtask

    task automatic checkStatus(input string tag, input logic [4:0] exp);
        checkOutput(tag, 32'({byte_ready, busy, cpu_hold, done, err}), 32'(exp));
    endtask

    logic [7:0] goodFrame[$];
    logic [7:0] badFrame[$];
    logic [7:0] emptyFrame[$];

    initial begin
        checkCount = 0;
        failCount  = 0;
        reset      = 1'b1;
        load_start = 1'b0;
        byte_in    = 8'h00;
        byte_valid = 1'b0;
        goodFrame  = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42};
        badFrame   = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h43};
        emptyFrame = '{8'h00, 8'h00, 8'h00};

        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        // {byte_ready, busy, cpu_hold, done, err}
        checkStatus("reset_status", 5'b00000);
        checkOutput("reset_wr_en", 32'(wr_en), 32'd0);
        checkOutput("reset_wr_addr", 32'(wr_addr), 32'h0000);
        checkOutput("reset_wr_data", 32'(wr_data), 32'h0000);

        // Normal load.
        pulseStart();
        checkStatus("start_status", 5'b11100);
        seenAddr.delete();
        seenData.delete();
        sendFrame(goodFrame, 0);
        checkStatus("normal_status", 5'b00010);
        checkOutput("normal_writes", 32'(seenAddr.size()), 32'd2);
        if (seenAddr.size() == 2) begin
            checkOutput("normal_addr0", 32'(seenAddr[0]), 32'h0000);
            checkOutput("normal_data0", 32'(seenData[0]), 32'h1234);
            checkOutput("normal_addr1", 32'(seenAddr[1]), 32'h0001);
            checkOutput("normal_data1", 32'(seenData[1]), 32'hABCD);
        end

        // Bad checksum, then a good reload from ERR.
        pulseStart();
        seenAddr.delete();
        seenData.delete();
        sendFrame(badFrame, 0);
        checkStatus("badchk_status", 5'b00101);
        checkOutput("badchk_writes", 32'(seenAddr.size()), 32'd2);
        checkOutput("badchk_hold_addr", 32'(wr_addr), 32'h0001);
        checkOutput("badchk_hold_data", 32'(wr_data), 32'hABCD);
        pulseStart();
        seenAddr.delete();
        seenData.delete();
        sendFrame(goodFrame, 0);
        checkStatus("reload_status", 5'b00010);
        checkOutput("reload_writes", 32'(seenAddr.size()), 32'd2);
        if (seenAddr.size() == 2) begin
            checkOutput("reload_addr0", 32'(seenAddr[0]), 32'h0000);
        end

        // Empty image.
        pulseStart();
        seenAddr.delete();
        sendFrame(emptyFrame, 0);
        checkStatus("empty_status", 5'b00010);
        checkOutput("empty_writes", 32'(seenAddr.size()), 32'd0);

        // Oversize count: ERR the cycle after the second byte.
        pulseStart();
        seenAddr.delete();
        applyStimulus(8'h01, 0);
        applyStimulus(8'h01, 0);
        checkStatus("oversize_status", 5'b00101);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("oversize_writes", 32'(seenAddr.size()), 32'd0);

        // Backpressure gaps, with a stray load_start mid-frame that must be ignored.
        pulseStart();
        seenAddr.delete();
        seenData.delete();
        applyStimulus(8'h00, 5);
        pulseStart();
        for (int i = 1; i < 7; i++) applyStimulus(goodFrame[i], 5);
        checkStatus("gap_status", 5'b00010);
        checkOutput("gap_writes", 32'(seenAddr.size()), 32'd2);
        if (seenData.size() == 2) begin
            checkOutput("gap_data0", 32'(seenData[0]), 32'h1234);
            checkOutput("gap_data1", 32'(seenData[1]), 32'hABCD);
        end

        // Timeout after a DATA_HI byte.
        pulseStart();
        applyStimulus(8'h00, 0);
        applyStimulus(8'h01, 0);
        applyStimulus(8'h12, 0);
        repeat (TB_TIMEOUT - 2) @(posedge clk);
        #1;
        checkStatus("timeout_before", 5'b11100);
        repeat (3) @(posedge clk);
        #1;
        checkStatus("timeout_after", 5'b00101);

        // Reset coincident with a DATA_LO transfer drops the write.
        pulseStart();
        seenAddr.delete();
        applyStimulus(8'h00, 0);
        applyStimulus(8'h01, 0);
        applyStimulus(8'h12, 0);
        byte_in    = 8'h34;
        byte_valid = 1'b1;
        reset      = 1'b1;
        @(posedge clk);
        #1;
        reset      = 1'b0;
        byte_valid = 1'b0;
        checkOutput("rst_wr_en", 32'(wr_en), 32'd0);
        checkStatus("rst_status", 5'b00000);
        checkOutput("rst_wr_addr", 32'(wr_addr), 32'h0000);
        checkOutput("rst_wr_data", 32'(wr_data), 32'h0000);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_no_write", 32'(seenAddr.size()), 32'd0);
        checkStatus("rst_idle", 5'b00000);

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
